// File: rtl/spram_arb_pkg.sv
// rtl/spram_arb_pkg.sv - shared types and round-robin pick helper for the SPRAM burst arbiter
package spram_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} TYPE_ARB_ST;

  localparam int ARB_MAXREQ = 8;

  // First asserted requester scanning ptr, ptr+1, ... mod nreq; returns ptr when none is valid.
  function automatic logic [2:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr, input int nreq);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < ARB_MAXREQ; i++) begin
      idx = (int'(ptr) + i) % nreq;
      if (!found && (i < nreq) && valid[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/spram_arb_rpipe.sv
// rtl/spram_arb_rpipe.sv - fixed-depth valid/index delay line matching the RAM read latency
module spram_arb_rpipe #(
  parameter int DEPTH = 1,
  parameter int IDXW  = 2
) (
  input  logic            i_clk,
  input  logic            i_clr,
  input  logic            i_push_vld,
  input  logic [IDXW-1:0] i_push_idx,
  output logic            o_vld,
  output logic [IDXW-1:0] o_idx
);

  logic [DEPTH-1:0] r_vld;
  logic [IDXW-1:0]  r_idx [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_vld <= '0;
      for (int k = 0; k < DEPTH; k++) r_idx[k] <= '0;
    end else begin
      r_vld[0] <= i_push_vld;
      r_idx[0] <= i_push_idx;
      for (int k = DEPTH - 1; k > 0; k--) begin
        r_vld[k] <= r_vld[k-1];
        r_idx[k] <= r_idx[k-1];
      end
    end
  end

  assign o_vld = r_vld[DEPTH-1];
  assign o_idx = r_idx[DEPTH-1];

endmodule

// File: rtl/spram_burst_arb.sv
// rtl/spram_burst_arb.sv - round-robin burst-locked arbiter sharing one single-port RAM
// Optional per-grant beat limit enabled by SPRAM_ARB_MAXBURST_EN.
module spram_burst_arb
  import spram_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int AXI_AW     = 40,
  parameter int AXI_DW     = 128,
  parameter int AXI_WSTRBW = AXI_DW / 8,
  parameter int SLV_WS     = 1,
  parameter int MAX_BEATS  = 16,
  parameter int IDXW       = $clog2(NREQ)
) (
  input  logic                       RAM_CLK,
  input  logic                       RAM_RESET,
  input  logic [NREQ-1:0]            REQ_VALID,
  output logic [NREQ-1:0]            REQ_READY,
  input  logic [NREQ-1:0]            REQ_WE,
  input  logic [NREQ-1:0]            REQ_LAST,
  input  logic [NREQ*AXI_AW-1:0]     REQ_ADDR,
  input  logic [NREQ*AXI_DW-1:0]     REQ_WDATA,
  input  logic [NREQ*AXI_WSTRBW-1:0] REQ_WSTRB,
  output logic [NREQ-1:0]            RSP_VALID,
  output logic [AXI_DW-1:0]          RSP_DATA,
  output logic [IDXW-1:0]            OWNER,
  output logic                       BUSY,
  output logic [AXI_AW-1:0]          RAM_A,
  output logic                       RAM_CEN,
  output logic [AXI_DW-1:0]          RAM_D,
  output logic [AXI_WSTRBW-1:0]      RAM_WEN,
  input  logic [AXI_DW-1:0]          RAM_Q
);

  TYPE_ARB_ST      r_state, w_state_nxt;
  logic [IDXW-1:0] r_owner, w_owner_nxt;
  logic [IDXW-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [IDXW-1:0] w_pick, w_owner_inc, w_rsp_idx;
  logic            w_grant, w_fire, w_cap, w_end, w_rsp_vld;
  logic            w_owner_vld, w_owner_we, w_owner_last;

  assign w_pick       = IDXW'(rr_pick(8'(REQ_VALID), 3'(r_rr_ptr), NREQ));
  assign w_owner_inc  = (r_owner == IDXW'(NREQ - 1)) ? '0 : r_owner + IDXW'(1);
  assign w_owner_vld  = REQ_VALID[r_owner];
  assign w_owner_we   = REQ_WE[r_owner];
  assign w_owner_last = REQ_LAST[r_owner];

  // Reset also gates the beat handshake so an abandoned burst never touches the RAM.
  assign w_grant = (r_state == ARB_GRANT) && !RAM_RESET;
  assign w_fire  = w_grant && w_owner_vld;

  assign REQ_READY = w_fire ? (NREQ'(1) << r_owner) : '0;
  assign RAM_CEN   = ~w_fire;
  assign RAM_A     = w_fire ? REQ_ADDR[r_owner*AXI_AW +: AXI_AW] : '0;
  assign RAM_D     = w_fire ? REQ_WDATA[r_owner*AXI_DW +: AXI_DW] : '0;
  assign RAM_WEN   = ~(REQ_WSTRB[r_owner*AXI_WSTRBW +: AXI_WSTRBW] & {AXI_WSTRBW{w_fire & w_owner_we}});
  assign BUSY      = (r_state == ARB_GRANT) && !RAM_RESET;
  assign OWNER     = RAM_RESET ? '0 : r_owner;

`ifdef SPRAM_ARB_MAXBURST_EN
  localparam int CNTW = $clog2(MAX_BEATS + 1);
  logic [CNTW-1:0] r_beat_cnt;

  always_ff @(posedge RAM_CLK) begin
    if (RAM_RESET || (r_state == ARB_IDLE)) r_beat_cnt <= '0;
    else if (w_fire)                        r_beat_cnt <= r_beat_cnt + CNTW'(1);
  end

  assign w_cap = (r_beat_cnt == CNTW'(MAX_BEATS - 1));
`else
  assign w_cap = 1'b0;
`endif

  assign w_end = w_fire && (w_owner_last || w_cap);

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      ARB_IDLE: begin
        if (|REQ_VALID) begin
          w_state_nxt = ARB_GRANT;
          w_owner_nxt = w_pick;
        end
      end
      ARB_GRANT: begin
        if (w_end) begin
          w_state_nxt  = ARB_IDLE;
          w_rr_ptr_nxt = w_owner_inc;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge RAM_CLK) begin
    if (RAM_RESET) begin
      r_state  <= ARB_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  spram_arb_rpipe #(
    .DEPTH (SLV_WS),
    .IDXW  (IDXW)
  ) u_rpipe (
    .i_clk      (RAM_CLK),
    .i_clr      (RAM_RESET),
    .i_push_vld (w_fire & ~w_owner_we),
    .i_push_idx (r_owner),
    .o_vld      (w_rsp_vld),
    .o_idx      (w_rsp_idx)
  );

  assign RSP_VALID = (w_rsp_vld && !RAM_RESET) ? (NREQ'(1) << w_rsp_idx) : '0;
  assign RSP_DATA  = (w_rsp_vld && !RAM_RESET) ? RAM_Q : '0;

endmodule

// File: tb/tb_spram_burst_arb.sv
// tb/tb_spram_burst_arb.sv - directed bench for spram_burst_arb with a behavioural SPRAM model
module tb_spram_burst_arb;

  localparam int NREQ = 4, AW = 40, DW = 128, SW = 16, SLV_WS = 3, MAXB = 4, IDXW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [NREQ-1:0]      REQ_VALID, REQ_READY, REQ_WE, REQ_LAST, RSP_VALID;
  logic [NREQ*AW-1:0]   REQ_ADDR;
  logic [NREQ*DW-1:0]   REQ_WDATA;
  logic [NREQ*SW-1:0]   REQ_WSTRB;
  logic [DW-1:0]        RSP_DATA, RAM_D, RAM_Q;
  logic [IDXW-1:0]      OWNER;
  logic                 BUSY, RAM_CEN;
  logic [AW-1:0]        RAM_A;
  logic [SW-1:0]        RAM_WEN;

  spram_burst_arb #(
    .NREQ(NREQ), .AXI_AW(AW), .AXI_DW(DW), .SLV_WS(SLV_WS), .MAX_BEATS(MAXB)
  ) dut (
    .RAM_CLK(clk), .RAM_RESET(rst),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE), .REQ_LAST(REQ_LAST),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_WSTRB(REQ_WSTRB),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .OWNER(OWNER), .BUSY(BUSY),
    .RAM_A(RAM_A), .RAM_CEN(RAM_CEN), .RAM_D(RAM_D), .RAM_WEN(RAM_WEN), .RAM_Q(RAM_Q)
  );

  // Single-port RAM with SLV_WS cycles of read latency
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] qp [SLV_WS];
  assign RAM_Q = qp[SLV_WS-1];

  always @(posedge clk) begin
    logic [DW-1:0] rd;
    logic [DW-1:0] cur;
    rd = '0;
    if (RAM_CEN === 1'b0) begin
      cur = mem.exists(RAM_A) ? mem[RAM_A] : '0;
      if (&RAM_WEN) rd = cur;
      else begin
        for (int b = 0; b < SW; b++) if (!RAM_WEN[b]) cur[b*8 +: 8] = RAM_D[b*8 +: 8];
        mem[RAM_A] = cur;
      end
    end
    for (int k = SLV_WS - 1; k > 0; k--) qp[k] <= qp[k-1];
    qp[0] <= rd;
  end

  typedef struct {logic we; logic last; logic [AW-1:0] a; logic [DW-1:0] d; logic [SW-1:0] s;} beat_t;
  typedef struct {int cyc; int req; logic we; logic [AW-1:0] a; logic [SW-1:0] wen; int owner;} fire_t;
  typedef struct {int cyc; int req; logic [DW-1:0] d;} rsp_t;

  beat_t bq [NREQ][$];
  bit    hold [NREQ];
  bit    fired [NREQ];
  fire_t flog [$];
  rsp_t  rlog [$];
  int    cyc, n_tests, n_fail;
  logic [NREQ-1:0] s_ready;
  logic            s_cen, s_busy;
  logic [IDXW-1:0] s_owner;
  logic [DW-1:0]   wdat [4];

  task automatic push_beat(input int r, input logic we, input logic last, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
    beat_t b;
    b.we = we; b.last = last; b.a = a; b.d = d; b.s = s;
    bq[r].push_back(b);
  endtask

  task automatic apply_drive();
    for (int i = 0; i < NREQ; i++) begin
      if (bq[i].size() > 0 && !hold[i]) begin
        REQ_VALID[i] = 1'b1;
        REQ_WE[i]    = bq[i][0].we;
        REQ_LAST[i]  = bq[i][0].last;
        REQ_ADDR[i*AW +: AW]  = bq[i][0].a;
        REQ_WDATA[i*DW +: DW] = bq[i][0].d;
        REQ_WSTRB[i*SW +: SW] = bq[i][0].s;
      end else begin
        REQ_VALID[i] = 1'b0;
        REQ_WE[i]    = 1'b0;
        REQ_LAST[i]  = 1'b0;
      end
    end
  endtask

  // One clock: sample at the falling edge, advance the requester queues after the rising edge.
  task automatic step();
    @(negedge clk);
    s_ready = REQ_READY; s_cen = RAM_CEN; s_busy = BUSY; s_owner = OWNER;
    for (int i = 0; i < NREQ; i++) begin
      fired[i] = (REQ_VALID[i] === 1'b1) && (REQ_READY[i] === 1'b1);
      if (fired[i]) flog.push_back('{cyc, i, REQ_WE[i], RAM_A, RAM_WEN, int'(OWNER)});
      if (RSP_VALID[i] === 1'b1) rlog.push_back('{cyc, i, RSP_DATA});
    end
    @(posedge clk); #1;
    cyc++;
    for (int i = 0; i < NREQ; i++) if (fired[i]) void'(bq[i].pop_front());
    apply_drive();
  endtask

  function automatic bit pending();
    for (int i = 0; i < NREQ; i++) if (bq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input int extra);
    int guard;
    guard = 0;
    while (pending() && guard < 400) begin step(); guard++; end
    n_tests++;
    if (guard >= 400) begin $display("FAIL drain_timeout got=%0d cycles required<400", guard); n_fail++; end
    repeat (extra) step();
  endtask

  task automatic wait_fire(input string nm);
    int guard;
    guard = 0;
    while (flog.size() == 0 && guard < 20) begin step(); guard++; end
    n_tests++;
    if (flog.size() == 0) begin $display("FAIL %s_first_fire got=none required=one fire", nm); n_fail++; end
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    apply_drive();
    step(); step();
    n_tests++; if (REQ_READY !== '0)  begin $display("FAIL reset_ready got=%h required=0", REQ_READY); n_fail++; end
    n_tests++; if (RSP_VALID !== '0)  begin $display("FAIL reset_rspv got=%h required=0", RSP_VALID); n_fail++; end
    n_tests++; if (RAM_CEN !== 1'b1)  begin $display("FAIL reset_cen got=%b required=1", RAM_CEN); n_fail++; end
    n_tests++; if (RAM_WEN !== 16'hFFFF) begin $display("FAIL reset_wen got=%h required=ffff", RAM_WEN); n_fail++; end
    n_tests++; if (OWNER !== 2'd0)    begin $display("FAIL reset_owner got=%0d required=0", OWNER); n_fail++; end
    n_tests++; if (BUSY !== 1'b0)     begin $display("FAIL reset_busy got=%b required=0", BUSY); n_fail++; end
    n_tests++; if (RAM_A !== '0 || RAM_D !== '0 || RSP_DATA !== '0)
      begin $display("FAIL reset_data got=%h/%h/%h required=0", RAM_A, RAM_D, RSP_DATA); n_fail++; end
    rst = 1'b0;
  endtask

  task automatic test_single();
    flog.delete(); rlog.delete();
    for (int k = 0; k < 4; k++) begin
      wdat[k] = {4{32'hA500_0000 | k}};
      push_beat(0, 1'b1, k == 3, 40'h100 + 40'(16 * k), wdat[k], 16'hFFFF);
    end
    for (int k = 0; k < 4; k++) push_beat(0, 1'b0, k == 3, 40'h100 + 40'(16 * k), '0, 16'hFFFF);
    apply_drive();
    drain(SLV_WS + 2);
    n_tests++; if (flog.size() != 8) begin $display("FAIL single_fires got=%0d required=8", flog.size()); n_fail++; end
    for (int k = 0; k < 8 && k < flog.size(); k++) begin
      n_tests++;
      if (flog[k].req != 0 || flog[k].wen !== ((k < 4) ? 16'h0000 : 16'hFFFF) || flog[k].a !== 40'h100 + 40'(16 * (k % 4)))
        begin $display("FAIL single_beat%0d got=req%0d wen=%h a=%h", k, flog[k].req, flog[k].wen, flog[k].a); n_fail++; end
    end
    n_tests++; if (rlog.size() != 4) begin $display("FAIL single_rsps got=%0d required=4", rlog.size()); n_fail++; end
    for (int k = 0; k < 4 && k < rlog.size() && flog.size() == 8; k++) begin
      n_tests++;
      if (rlog[k].req != 0 || rlog[k].d !== wdat[k] || rlog[k].cyc != flog[4+k].cyc + SLV_WS)
        begin $display("FAIL single_rsp%0d got=req%0d d=%h cyc=%0d required d=%h cyc=%0d", k, rlog[k].req,
                       rlog[k].d, rlog[k].cyc, wdat[k], flog[4+k].cyc + SLV_WS); n_fail++; end
    end
  endtask

  task automatic test_fairness();
    int exp_req [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int exp_off [10] = '{0, 1, 3, 4, 6, 7, 9, 10, 12, 13};
    do_reset();
    flog.delete(); rlog.delete();
    for (int r = 0; r < NREQ; r++)
      for (int b = 0; b < ((r == 0) ? 4 : 2); b++)
        push_beat(r, 1'b1, b % 2 == 1, 40'h1000 + 40'(r * 256 + b * 16), 128'(r * 16 + b), 16'hFFFF);
    apply_drive();
    drain(2);
    n_tests++; if (flog.size() != 10) begin $display("FAIL fair_fires got=%0d required=10", flog.size()); n_fail++; end
    for (int k = 0; k < 10 && k < flog.size(); k++) begin
      n_tests++;
      if (flog[k].req != exp_req[k] || flog[k].owner != exp_req[k] || flog[k].cyc - flog[0].cyc != exp_off[k])
        begin $display("FAIL fair_beat%0d got=req%0d own%0d off%0d required=req%0d off%0d", k, flog[k].req,
                       flog[k].owner, flog[k].cyc - flog[0].cyc, exp_req[k], exp_off[k]); n_fail++; end
    end
  endtask

  task automatic test_gapped();
    flog.delete(); rlog.delete();
    push_beat(2, 1'b1, 1'b0, 40'h2000, 128'h21, 16'hFFFF);
    apply_drive();
    wait_fire("gap");
    hold[2] = 1'b1;
    push_beat(2, 1'b1, 1'b0, 40'h2010, 128'h22, 16'hFFFF);
    push_beat(2, 1'b1, 1'b1, 40'h2020, 128'h23, 16'hFFFF);
    push_beat(1, 1'b1, 1'b1, 40'h2100, 128'h11, 16'hFFFF);
    apply_drive();
    for (int g = 0; g < 3; g++) begin
      step();
      n_tests++;
      if ({s_ready, s_cen, s_owner, s_busy} !== {4'b0000, 1'b1, 2'd2, 1'b1})
        begin $display("FAIL gap_hold%0d got=rdy%b cen%b own%0d busy%b required=rdy0000 cen1 own2 busy1",
                       g, s_ready, s_cen, s_owner, s_busy); n_fail++; end
    end
    hold[2] = 1'b0;
    apply_drive();
    drain(2);
    n_tests++; if (flog.size() != 4) begin $display("FAIL gap_fires got=%0d required=4", flog.size()); n_fail++; end
    if (flog.size() == 4) begin
      n_tests++;
      if (flog[1].req != 2 || flog[2].req != 2 || flog[3].req != 1 || flog[3].cyc != flog[2].cyc + 2)
        begin $display("FAIL gap_order got=%0d,%0d,%0d dcyc=%0d required=2,2,1 dcyc=2", flog[1].req, flog[2].req,
                       flog[3].req, flog[3].cyc - flog[2].cyc); n_fail++; end
    end
  endtask

  task automatic test_latency();
    logic [DW-1:0] x;
    x = {4{32'h5A5A_0110}};
    flog.delete(); rlog.delete();
    push_beat(1, 1'b0, 1'b0, 40'h100, '0, 16'hFFFF);
    push_beat(1, 1'b1, 1'b0, 40'h110, x, 16'hFFFF);
    push_beat(1, 1'b0, 1'b1, 40'h110, '0, 16'hFFFF);
    apply_drive();
    drain(SLV_WS + 2);
    n_tests++; if (flog.size() != 3 || rlog.size() != 2)
      begin $display("FAIL lat_counts got=fires%0d rsps%0d required=fires3 rsps2", flog.size(), rlog.size()); n_fail++; end
    if (flog.size() == 3 && rlog.size() == 2) begin
      n_tests++;
      if (rlog[0].req != 1 || rlog[0].cyc != flog[0].cyc + SLV_WS || rlog[0].d !== wdat[0])
        begin $display("FAIL lat_rsp0 got=req%0d dcyc=%0d d=%h required=req1 dcyc=%0d d=%h", rlog[0].req,
                       rlog[0].cyc - flog[0].cyc, rlog[0].d, SLV_WS, wdat[0]); n_fail++; end
      n_tests++;
      if (rlog[1].req != 1 || rlog[1].cyc != flog[2].cyc + SLV_WS || rlog[1].d !== x)
        begin $display("FAIL lat_rsp1 got=req%0d dcyc=%0d d=%h required=req1 dcyc=%0d d=%h", rlog[1].req,
                       rlog[1].cyc - flog[2].cyc, rlog[1].d, SLV_WS, x); n_fail++; end
    end
  endtask

  task automatic test_reset_mid();
    flog.delete(); rlog.delete();
    for (int k = 0; k < 4; k++) push_beat(3, 1'b0, k == 3, 40'h100 + 40'(16 * k), '0, 16'hFFFF);
    apply_drive();
    wait_fire("rstmid");
    rst = 1'b1;
    step(); step();
    n_tests++;
    if ({s_ready, s_cen, s_owner, s_busy} !== {4'b0000, 1'b1, 2'd0, 1'b0})
      begin $display("FAIL rstmid_outs got=rdy%b cen%b own%0d busy%b required=rdy0000 cen1 own0 busy0",
                     s_ready, s_cen, s_owner, s_busy); n_fail++; end
    bq[3].delete();
    rst = 1'b0;
    push_beat(3, 1'b0, 1'b1, 40'h110, '0, 16'hFFFF);
    push_beat(0, 1'b0, 1'b1, 40'h120, '0, 16'hFFFF);
    apply_drive();
    drain(SLV_WS + 2);
    n_tests++; if (flog.size() != 3) begin $display("FAIL rstmid_fires got=%0d required=3", flog.size()); n_fail++; end
    if (flog.size() == 3) begin
      n_tests++;
      if (flog[1].req != 0 || flog[2].req != 3)
        begin $display("FAIL rstmid_order got=%0d,%0d required=0,3", flog[1].req, flog[2].req); n_fail++; end
      n_tests++;
      if (rlog.size() != 2 || rlog[0].req != 0 || rlog[0].cyc != flog[1].cyc + SLV_WS)
        begin $display("FAIL rstmid_rsps got=n%0d required=n2 first from req0 at fire+%0d", rlog.size(), SLV_WS); n_fail++; end
    end
  endtask

`ifdef SPRAM_ARB_MAXBURST_EN
  task automatic test_maxburst();
    int exp_req [12] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    do_reset();
    flog.delete(); rlog.delete();
    for (int k = 0; k < 10; k++) push_beat(0, 1'b1, k == 9, 40'h3000 + 40'(16 * k), 128'(k), 16'hFFFF);
    for (int k = 0; k < 2; k++)  push_beat(1, 1'b1, k == 1, 40'h3100 + 40'(16 * k), 128'(k), 16'hFFFF);
    apply_drive();
    drain(2);
    n_tests++; if (flog.size() != 12) begin $display("FAIL maxb_fires got=%0d required=12", flog.size()); n_fail++; end
    for (int k = 0; k < 12 && k < flog.size(); k++) begin
      n_tests++;
      if (flog[k].req != exp_req[k])
        begin $display("FAIL maxb_beat%0d got=req%0d required=req%0d", k, flog[k].req, exp_req[k]); n_fail++; end
    end
  endtask
`endif

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    rst = 1'b1;
    REQ_VALID = '0; REQ_WE = '0; REQ_LAST = '0;
    REQ_ADDR = '0; REQ_WDATA = '0; REQ_WSTRB = '0;
    for (int i = 0; i < NREQ; i++) hold[i] = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_gapped();
    test_latency();
    test_reset_mid();
`ifdef SPRAM_ARB_MAXBURST_EN
    test_maxburst();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spram_burst_arb.md
Name: spram_burst_arb

Overview:
- Round-robin, burst-locked arbiter that shares one single-port RAM between NREQ beat-level requesters. Typical requesters are asi read/write engines or DMA ports.
- Owns the RAM pins (A/CEN/D/WEN/Q) and returns read data to the issuing requester after the RAM's fixed wait states.
- Sits between multiple AXI slave back-ends and one SPRAM macro. Generalises the fixed read/write priority scheme to N ports with fairness.

Parameters:
- NREQ, 4, number of requesters (2..8)
- AXI_AW, 40, RAM address width
- AXI_DW, 128, RAM data width
- AXI_WSTRBW, AXI_DW/8, byte-strobe width
- SLV_WS, 1, RAM read latency in cycles from CEN-low to valid RAM_Q (1..4)
- MAX_BEATS, 16, beat limit per grant; used only with SPRAM_ARB_MAXBURST_EN
- IDXW, $clog2(NREQ), requester index width

Ports:
- RAM_CLK  in  1  sole clock
- RAM_RESET  in  1  synchronous, active-high reset
- REQ_VALID  in  NREQ  beat request per requester
- REQ_READY  out  NREQ  beat accepted (one-hot or zero)
- REQ_WE  in  NREQ  1 = write beat, 0 = read beat
- REQ_LAST  in  NREQ  final beat of the burst
- REQ_ADDR  in  NREQ*AXI_AW  packed addresses, requester i at slice i
- REQ_WDATA  in  NREQ*AXI_DW  packed write data
- REQ_WSTRB  in  NREQ*AXI_WSTRBW  packed byte strobes
- RSP_VALID  out  NREQ  read data valid, one-hot
- RSP_DATA  out  AXI_DW  read data, shared by all requesters
- OWNER  out  IDXW  current grant index (debug)
- BUSY  out  1  a burst is granted
- RAM_A  out  AXI_AW  RAM address
- RAM_CEN  out  1  RAM enable, active-low
- RAM_D  out  AXI_DW  RAM write data
- RAM_WEN  out  AXI_WSTRBW  per-byte write enable, active-low
- RAM_Q  in  AXI_DW  RAM read data

Behaviour:
- Clock and reset: one clock RAM_CLK. RAM_RESET is synchronous and active-high.
- Values held while RAM_RESET=1:
  - FSM = IDLE, rr_ptr = 0, OWNER = 0, BUSY = 0, beat counter = 0.
  - Read-return pipe cleared.
  - REQ_READY = 0, RSP_VALID = 0, RAM_CEN = 1, RAM_WEN = all 1.
  - RAM_A, RAM_D and RSP_DATA are don't-care but driven to 0.
- Reset mid-burst: abandons the burst with no further RAM access. In-flight reads are dropped, so no RSP_VALID appears after reset.
- FSM states IDLE and GRANT.
- IDLE, arbitration:
  - If any REQ_VALID is high, choose the first requester scanning rr_ptr, rr_ptr+1, … mod NREQ.
  - Register the choice into OWNER and go to GRANT next cycle. This gives 1 cycle of arbitration latency.
  - REQ_READY = 0 while in IDLE.
- GRANT, beat handling:
  - REQ_READY[OWNER] = REQ_VALID[OWNER]. All other READY bits are 0.
  - fire = REQ_VALID[OWNER] & REQ_READY[OWNER].
  - The RAM is driven combinationally from the owner's slice only when fire is high:
    - RAM_CEN = ~fire
    - RAM_A = owner addr
    - RAM_D = owner wdata
    - RAM_WEN = ~(owner wstrb & {WSTRBW{fire & we}})
  - Gaps inside a burst are allowed: with VALID low, the grant is held and RAM_CEN stays 1.
- Burst end:
  - fire & REQ_LAST[OWNER] → IDLE, with rr_ptr = OWNER+1 mod NREQ.
  - One bubble cycle always separates bursts.
- Read return:
  - Each read fire pushes {1, OWNER} into an SLV_WS-deep shift pipe.
  - At the pipe output: RSP_VALID[idx] = 1 and RSP_DATA = RAM_Q, for exactly one cycle.
  - There is no backpressure; requesters must sink read data.
  - Write fires push {0, x}.
- Simultaneous events:
  - Multiple VALIDs in IDLE: round-robin choice.
  - A requester deasserting VALID before LAST keeps the grant. This is legal; there is no timeout unless the optional feature is enabled.
- Width rules: index arithmetic is mod NREQ (wraps NREQ-1→0). Packed slices use index × width.

Optional Feature:
- Macro: SPRAM_ARB_MAXBURST_EN.
- Defined:
  - A beat counter counts fires in GRANT.
  - When the counter reaches MAX_BEATS-1 and a fire occurs without LAST, the FSM returns to IDLE and rr_ptr advances (forced re-arbitration).
  - The preempted requester re-competes and continues its burst on its next grant. Its addresses are self-managed, so data integrity is preserved.
  - The counter clears on IDLE.
- Undefined: no counter; a grant lasts until LAST.

Decomposition:
- Package spram_arb_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_GRANT} TYPE_ARB_ST
  - function rr_pick(valid, ptr) returning the index
- One sub-module, spram_arb_rpipe: SLV_WS-deep valid/index delay line with synchronous clear.

Test Plan:
- Single requester: req0 writes 4 beats at addr 0x100..0x130 with strobe 0xFFFF, then reads 4 beats → RAM_WEN=0 on the writes. RSP_VALID[0] pulses 4 times, each SLV_WS=1 cycle after its fire, with the written data.
- Fairness: all 4 requesters hold VALID with 2-beat bursts → grant order 0,1,2,3,0. Each burst is followed by exactly one IDLE cycle. OWNER matches the order.
- Gapped burst: req2 owns the grant and drops VALID for 3 cycles mid-burst while req1 is valid → grant stays with req2, RAM_CEN=1 during the gap, req1 READY=0 until after req2's LAST.
- Latency: SLV_WS=3, read-write-read interleave by req1 → RSP_VALID[1] appears exactly 3 cycles after each read fire and never for the write.
- Reset mid-burst: assert RAM_RESET on the 2nd beat of a 4-beat read, with 1 read in flight → no RSP_VALID afterwards. All outputs take reset values the next cycle. rr_ptr=0, so req0 wins the next arbitration.
- With SPRAM_ARB_MAXBURST_EN and MAX_BEATS=4: req0 issues a 10-beat burst while req1 is valid → req0 gets 4 beats, req1 gets its burst, then req0 resumes.
